// File: rtl/dm_store_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dm_store_ctrl_if
//  Description : Bundle of per-core write requests/acks and the DM write port
//                used by the four-core data-memory store controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dm_store_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic [3:0]        MW;
   logic [ADDR_W-1:0] WADDR1;
   logic [ADDR_W-1:0] WADDR2;
   logic [ADDR_W-1:0] WADDR3;
   logic [ADDR_W-1:0] WADDR4;
   logic [DATA_W-1:0] WDATA1;
   logic [DATA_W-1:0] WDATA2;
   logic [DATA_W-1:0] WDATA3;
   logic [DATA_W-1:0] WDATA4;
   logic [3:0]        WACK;
   logic              DM_WE;
   logic [ADDR_W-1:0] DM_ADDR;
   logic [DATA_W-1:0] DM_DIN;
   logic              BUSY;
   logic [3:0]        ERR;

   // Core side: raises requests, observes acks and status.
   modport master (
      output MW, WADDR1, WADDR2, WADDR3, WADDR4,
             WDATA1, WDATA2, WDATA3, WDATA4,
      input  WACK, DM_WE, DM_ADDR, DM_DIN, BUSY, ERR
   );

   // Controller side.
   modport slave (
      input  MW, WADDR1, WADDR2, WADDR3, WADDR4,
             WDATA1, WDATA2, WDATA3, WDATA4,
      output WACK, DM_WE, DM_ADDR, DM_DIN, BUSY, ERR
   );
endinterface
`default_nettype wire

// File: rtl/dm_store_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dm_store_ctrl
//  Description : Four-core write-back controller. Captures level requests into
//                per-core slots, arbitrates round-robin onto a single DM write
//                port (one write per two cycles) and returns a 4-phase ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_store_ctrl #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int DM_DEPTH = 256
) (
   input  wire logic       clk,
   input  wire logic       reset,
   dm_store_ctrl_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

   // One extra bit so DM_DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DM_DEPTH);

   state_t            state_q, state_d;
   logic [3:0]        pending_q, pending_d;
   logic [ADDR_W-1:0] slot_addr_q [4];
   logic [ADDR_W-1:0] slot_addr_d [4];
   logic [DATA_W-1:0] slot_data_q [4];
   logic [DATA_W-1:0] slot_data_d [4];
   logic [1:0]        ptr_q, ptr_d;
   logic [1:0]        grant_q, grant_d;
   logic              dm_we_q, dm_we_d;
   logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
   logic [DATA_W-1:0] dm_din_q, dm_din_d;
   logic [3:0]        wack_q, wack_d;
   logic [3:0]        err_q, err_d;

   logic [ADDR_W-1:0] w_waddr [4];
   logic [DATA_W-1:0] w_wdata [4];
   logic              w_found;
   logic [1:0]        w_gsel;
   logic              w_in_range;

   // Gather the per-core address/data buses into indexable arrays.
   always_comb begin
      w_waddr[0] = bus.WADDR1;
      w_waddr[1] = bus.WADDR2;
      w_waddr[2] = bus.WADDR3;
      w_waddr[3] = bus.WADDR4;
      w_wdata[0] = bus.WDATA1;
      w_wdata[1] = bus.WDATA2;
      w_wdata[2] = bus.WDATA3;
      w_wdata[3] = bus.WDATA4;
   end

   // Round-robin search: first pending slot after the last grant.
   always_comb begin
      logic [1:0] idx;
      w_found = 1'b0;
      w_gsel  = ptr_q;
      idx     = ptr_q;
      for (int off = 1; off <= 4; off++) begin
         idx = ptr_q + 2'(off);
         if (!w_found && pending_q[idx]) begin
            w_found = 1'b1;
            w_gsel  = idx;
         end
      end
      w_in_range = ({1'b0, slot_addr_q[w_gsel]} < c_depth);
   end

   // Next-state: slot capture, ack release and the IDLE/WRITE sequencer.
   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      slot_addr_d = slot_addr_q;
      slot_data_d = slot_data_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      dm_we_d     = dm_we_q;
      dm_addr_d   = dm_addr_q;
      dm_din_d    = dm_din_q;
      wack_d      = wack_q;
      err_d       = err_q;

      for (int i = 0; i < 4; i++) begin
         // A core whose write is in flight has neither pending nor WACK set
         // yet, so it must be masked explicitly to avoid a duplicate capture.
         if (bus.MW[i] && !wack_q[i] && !pending_q[i] &&
             !((state_q == ST_WRITE) && (grant_q == 2'(i)))) begin
            pending_d[i]   = 1'b1;
            slot_addr_d[i] = w_waddr[i];
            slot_data_d[i] = w_wdata[i];
         end
         if (!bus.MW[i]) begin
            wack_d[i] = 1'b0;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (w_found) begin
               pending_d[w_gsel] = 1'b0;
               grant_d           = w_gsel;
               ptr_d             = w_gsel;
               dm_addr_d         = slot_addr_q[w_gsel];
               dm_din_d          = slot_data_q[w_gsel];
               if (w_in_range) begin
                  dm_we_d = 1'b1;
               end else begin
                  err_d[w_gsel] = 1'b1;
               end
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            dm_we_d         = 1'b0;
            wack_d[grant_q] = 1'b1;
            state_d         = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register with synchronous reset; slots need no reset since
   // pending bits gate every use of them.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pending_q <= 4'b0000;
         ptr_q     <= 2'd3;
         grant_q   <= 2'd0;
         dm_we_q   <= 1'b0;
         dm_addr_q <= '0;
         dm_din_q  <= '0;
         wack_q    <= 4'b0000;
         err_q     <= 4'b0000;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         dm_we_q   <= dm_we_d;
         dm_addr_q <= dm_addr_d;
         dm_din_q  <= dm_din_d;
         wack_q    <= wack_d;
         err_q     <= err_d;
      end
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
   end

   // Drive the interface outputs; BUSY is purely combinational.
   always_comb begin
      bus.WACK    = wack_q;
      bus.DM_WE   = dm_we_q;
      bus.DM_ADDR = dm_addr_q;
      bus.DM_DIN  = dm_din_q;
      bus.ERR     = err_q;
      bus.BUSY    = (|pending_q) | (state_q == ST_WRITE);
   end

endmodule
`default_nettype wire

// File: tb/tb_dm_store_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_store_ctrl
//  Description : Directed self-checking bench for dm_store_ctrl with a small
//                behavioural DM that commits on DM_WE.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_store_ctrl;

   logic clk = 1'b0;
   logic reset;

   int n_vec = 0;
   int n_err = 0;

   dm_store_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   dm_store_ctrl #(.ADDR_W(16), .DATA_W(16), .DM_DEPTH(256)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural data memory plus a log of every committed write.
   logic [15:0] dm_mem [0:255];
   logic [15:0] wr_addr_q [$];
   logic [15:0] wr_data_q [$];
   logic        we_prev = 1'b0;
   int          n_consec = 0;

   always @(posedge clk) begin
      if (bus.DM_WE) begin
         if (bus.DM_ADDR < 16'd256) dm_mem[bus.DM_ADDR[7:0]] = bus.DM_DIN;
         wr_addr_q.push_back(bus.DM_ADDR);
         wr_data_q.push_back(bus.DM_DIN);
      end
      if (bus.DM_WE && we_prev) n_consec++;
      we_prev = bus.DM_WE;
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      bus.MW = 4'b0000;
      tick(2);
      reset = 1'b0;
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   initial begin
      for (int a = 0; a < 256; a++) dm_mem[a] = 16'h0000;
      reset      = 1'b1;
      bus.MW     = 4'b0000;
      bus.WADDR1 = '0; bus.WADDR2 = '0; bus.WADDR3 = '0; bus.WADDR4 = '0;
      bus.WDATA1 = '0; bus.WDATA2 = '0; bus.WDATA3 = '0; bus.WDATA4 = '0;
      do_reset();

      // Reset state
      check_value("rst_wack",  32'(bus.WACK),    32'h0);
      check_value("rst_we",    32'(bus.DM_WE),   32'h0);
      check_value("rst_addr",  32'(bus.DM_ADDR), 32'h0);
      check_value("rst_din",   32'(bus.DM_DIN),  32'h0);
      check_value("rst_err",   32'(bus.ERR),     32'h0);
      check_value("rst_busy",  32'(bus.BUSY),    32'h0);

      // Single write: core 1, addr 4, data 9
      bus.MW = 4'b0001; bus.WADDR1 = 16'd4; bus.WDATA1 = 16'd9;
      tick();
      check_value("s_cap_busy", 32'(bus.BUSY),  32'h1);
      check_value("s_cap_we",   32'(bus.DM_WE), 32'h0);
      tick();
      check_value("s_we",       32'(bus.DM_WE),   32'h1);
      check_value("s_addr",     32'(bus.DM_ADDR), 32'd4);
      check_value("s_din",      32'(bus.DM_DIN),  32'd9);
      check_value("s_wack_lo",  32'(bus.WACK),    32'h0);
      tick();
      check_value("s_we_off",   32'(bus.DM_WE),   32'h0);
      check_value("s_wack",     32'(bus.WACK),    32'h1);
      check_value("s_mem4",     32'(dm_mem[4]),   32'd9);
      check_value("s_hold_addr", 32'(bus.DM_ADDR), 32'd4);
      tick(3);
      check_value("s_wack_hold", 32'(bus.WACK),   32'h1);
      check_value("s_nwr",      32'(wr_addr_q.size()), 32'd1);
      bus.MW = 4'b0000;
      tick();
      check_value("s_wack_rel", 32'(bus.WACK),    32'h0);

      // All four at once
      do_reset();
      bus.WADDR1 = 16'd0; bus.WADDR2 = 16'd1; bus.WADDR3 = 16'd2; bus.WADDR4 = 16'd3;
      bus.WDATA1 = 16'd5; bus.WDATA2 = 16'd6; bus.WDATA3 = 16'd7; bus.WDATA4 = 16'd8;
      bus.MW = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         tick();
         check_value($sformatf("a_busy%0d", c), 32'(bus.BUSY), 32'h1);
      end
      tick();
      check_value("a_busy_end", 32'(bus.BUSY), 32'h0);
      check_value("a_wack",     32'(bus.WACK), 32'hF);
      check_value("a_nwr",      32'(wr_addr_q.size()), 32'd4);
      for (int c = 0; c < 4; c++) begin
         if (wr_addr_q.size() > c)
            check_value($sformatf("a_order%0d", c), 32'(wr_addr_q[c]), 32'(c));
         check_value($sformatf("a_mem%0d", c), 32'(dm_mem[c]), 32'(c + 5));
      end
      bus.MW = 4'b0000;
      tick();
      check_value("a_wack_rel", 32'(bus.WACK), 32'h0);

      // Round-robin: core 2 first, then cores 1 and 3 together
      do_reset();
      bus.MW = 4'b0010; bus.WADDR2 = 16'd20; bus.WDATA2 = 16'h000A;
      tick(3);
      check_value("rr_wack2", 32'(bus.WACK), 32'h2);
      bus.MW = 4'b0000;
      tick();
      wr_addr_q.delete();
      bus.WADDR1 = 16'd21; bus.WDATA1 = 16'h000B;
      bus.WADDR3 = 16'd22; bus.WDATA3 = 16'h000C;
      bus.MW = 4'b0101;
      tick(5);
      check_value("rr_nwr", 32'(wr_addr_q.size()), 32'd2);
      if (wr_addr_q.size() == 2) begin
         check_value("rr_first",  32'(wr_addr_q[0]), 32'd22);
         check_value("rr_second", 32'(wr_addr_q[1]), 32'd21);
      end
      check_value("rr_wack", 32'(bus.WACK), 32'h5);
      bus.MW = 4'b0000;
      tick();

      // Held request from core 3
      wr_addr_q.delete();
      bus.MW = 4'b0100; bus.WADDR3 = 16'd30; bus.WDATA3 = 16'h0033;
      tick(3);
      check_value("h_wack", 32'(bus.WACK), 32'h4);
      tick(10);
      check_value("h_nwr1", 32'(wr_addr_q.size()), 32'd1);
      check_value("h_busy", 32'(bus.BUSY), 32'h0);
      bus.MW = 4'b0000;
      tick();
      check_value("h_wack_rel", 32'(bus.WACK), 32'h0);
      bus.MW = 4'b0100; bus.WDATA3 = 16'h0044;
      tick(3);
      check_value("h_nwr2", 32'(wr_addr_q.size()), 32'd2);
      check_value("h_mem30", 32'(dm_mem[30]), 32'h44);
      bus.MW = 4'b0000;
      tick();

      // Address collision: cores 1 and 4 to addr 12
      do_reset();
      bus.WADDR1 = 16'd12; bus.WDATA1 = 16'd1;
      bus.WADDR4 = 16'd12; bus.WDATA4 = 16'd2;
      bus.MW = 4'b1001;
      tick(5);
      check_value("c_nwr",   32'(wr_addr_q.size()), 32'd2);
      check_value("c_mem12", 32'(dm_mem[12]), 32'd2);
      bus.MW = 4'b0000;
      tick();

      // Out of range from core 3
      do_reset();
      bus.WADDR3 = 16'd300; bus.WDATA3 = 16'h0055;
      bus.MW = 4'b0100;
      tick(3);
      check_value("o_nwr",  32'(wr_addr_q.size()), 32'd0);
      check_value("o_wack", 32'(bus.WACK), 32'h4);
      check_value("o_err",  32'(bus.ERR),  32'h4);
      bus.MW = 4'b0000;
      tick(2);
      check_value("o_wack_rel", 32'(bus.WACK), 32'h0);
      check_value("o_err_stk",  32'(bus.ERR),  32'h4);

      // Reset while cores 1 and 2 are pending
      bus.WADDR1 = 16'd40; bus.WDATA1 = 16'h0040;
      bus.WADDR2 = 16'd41; bus.WDATA2 = 16'h0041;
      bus.MW = 4'b0011;
      tick();
      check_value("r_busy_pre", 32'(bus.BUSY), 32'h1);
      reset  = 1'b1;
      bus.MW = 4'b0000;
      tick();
      reset = 1'b0;
      check_value("r_wack", 32'(bus.WACK),  32'h0);
      check_value("r_err",  32'(bus.ERR),   32'h0);
      check_value("r_busy", 32'(bus.BUSY),  32'h0);
      check_value("r_we",   32'(bus.DM_WE), 32'h0);
      tick(4);
      check_value("r_wack_after", 32'(bus.WACK), 32'h0);
      check_value("r_nwr",  32'(wr_addr_q.size()), 32'd0);
      check_value("r_mem40", 32'(dm_mem[40]), 32'h0);

      check_value("no_back_to_back_we", 32'(n_consec), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
